cistern_level_monitor: RTL
==========================

Name: cistern_level_monitor

Overview:
Consumer end of the cistern level-code interface: takes the 4-bit level code from the float-switch encoder, debounces it, and decodes it to a level 0..8. Drives a 7-segment digit, a hysteretic fill-pump controller and overflow/fault flags. Sits between the float-switch encoder and the panel/pump relay driver.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a code is accepted (>=2)
LOW_THR, 2, level at or below which the pump starts (0..7)
HIGH_THR, 7, level at or above which the pump stops (LOW_THR < HIGH_THR <= 8)
MAX_RUN_CYCLES, 1000000, pump-on limit without level rise (used only with the optional feature)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
level_code  input  4  raw level code from the encoder, asynchronous to nothing (same clk domain)
fault_clr  input  1  single-cycle request to leave FAULT
level  output  4  accepted level 0..8, binary
level_valid  output  1  high once a valid code has been accepted and no fault is active
seg  output  7  7-segment pattern {g,f,e,d,c,b,a}, active-high
pump_on  output  1  pump relay drive
overflow  output  1  accepted level == 8
fault  output  1  high in FAULT state

Behaviour:
- Code map: 0000..0001 -> levels 0,1; 1010 -> level 2; 0011..1000 -> levels 3..8; 1110 -> sensor fault; every other code (incl. 0010, 1001, 1011..1101, 1111) -> invalid, treated as fault.
- Debounce: level_code registered into code_q each cycle. stab_cnt clears to 0 when level_code != code_q, else increments, saturating at STABLE_CYCLES-1. When stab_cnt == STABLE_CYCLES-1 and level_code == code_q, acc_code loads code_q. A change held steady updates acc_code STABLE_CYCLES+1 cycles after it first appears; glitches shorter than STABLE_CYCLES never reach acc_code.
- All outputs registered; they reflect acc_code/FSM one cycle after acc_code updates.
- Reset: code_q=0, stab_cnt=0, acc_code=0, have_code=0, state=IDLE; level=0, level_valid=0, seg=0000000 (blank), pump_on=0, overflow=0, fault=0. Reset mid-fill drops pump_on on the next edge.
- have_code sets on first acceptance of any code; until then seg blank, FSM held in IDLE.
- FSM states IDLE (pump off), FILLING (pump on), FAULT (pump off).
  IDLE -> FILLING: accepted valid level <= LOW_THR.
  FILLING -> IDLE: accepted valid level >= HIGH_THR.
  IDLE/FILLING -> FAULT: accepted code is fault or invalid (priority over all other transitions).
  FAULT -> IDLE: fault_clr high and accepted code valid on the same cycle; otherwise stay. fault_clr outside FAULT ignored. Re-evaluation of LOW_THR happens the following cycle.
- Levels strictly between thresholds hold current pump state (hysteresis).
- level/overflow update only on valid accepted codes; in FAULT they hold last valid values, level_valid=0, seg shows 'E' (1111001).
- seg digits: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111.

Optional Feature:
DRY_RUN_TIMEOUT_EN: when defined, a run counter clears on entry to FILLING and whenever the accepted level increases; if it reaches MAX_RUN_CYCLES while in FILLING, FSM enters FAULT (seg 'E', pump off) and exits only by the normal fault_clr rule. When undefined, no counter exists and FILLING has no time limit.

Decomposition:
- cistern_pkg: level-code constants (incl. CODE_LVL2 = 1010, CODE_SENSOR_FAULT = 1110), state enum, 7-segment pattern constants, decode function code -> {valid, level}.
- Sub-module cistern_code_debounce (level_code in, acc_code + accept strobe out, STABLE_CYCLES parameter); FSM and display in the top.

Test Plan:
- Reset, drive 0000 steady -> after STABLE_CYCLES+1 cycles acc=0, next cycle level=0, seg=0111111, pump_on=1 (0 <= LOW_THR=2).
- From FILLING step codes 0011,0100..1000 each held 10 cycles -> pump_on stays 1 through level 6, drops when level 7 registers; at 1000 overflow=1, seg=1111111.
- From IDLE at level 7, drive 1010 -> level=2, seg=1011011, pump_on=1; 0010 instead -> fault=1, seg=1111001, pump_on=0.
- Glitch: hold 0101, pulse 0110 for 3 cycles (STABLE_CYCLES=4) -> level stays 5, no output change.
- In FAULT via 1110, pulse fault_clr while code still 1110 -> stays FAULT; switch to 0001, pulse fault_clr after acceptance -> IDLE then FILLING, pump_on=1.
- With DRY_RUN_TIMEOUT_EN, MAX_RUN_CYCLES=50, hold level 1 in FILLING -> fault=1 and pump_on=0 exactly 50 cycles after FILLING entry.

Source files
------------

// File: rtl/cistern_pkg.sv
// Shared definitions for the cistern level monitor: level-code constants,
// FSM state type, 7-segment patterns and the code -> level decoder.
package cistern_pkg;

    localparam logic [3:0] CODE_LVL0         = 4'b0000;
    localparam logic [3:0] CODE_LVL1         = 4'b0001;
    localparam logic [3:0] CODE_LVL2         = 4'b1010;
    localparam logic [3:0] CODE_LVL3         = 4'b0011;
    localparam logic [3:0] CODE_LVL4         = 4'b0100;
    localparam logic [3:0] CODE_LVL5         = 4'b0101;
    localparam logic [3:0] CODE_LVL6         = 4'b0110;
    localparam logic [3:0] CODE_LVL7         = 4'b0111;
    localparam logic [3:0] CODE_LVL8         = 4'b1000;
    localparam logic [3:0] CODE_SENSOR_FAULT = 4'b1110;

    localparam logic [3:0] LEVEL_MAX = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b1111001;

    typedef struct packed {
        logic       valid;
        logic [3:0] level;
    } decode_t;

    // Level 2 uses 1010 rather than 0010 so that a single stuck float
    // switch produces an invalid code instead of a plausible level.
    function automatic decode_t decode_code(input logic [3:0] code);
        decode_t d;
        d.valid = 1'b1;
        d.level = 4'd0;
        case (code)
            CODE_LVL0:         d.level = 4'd0;
            CODE_LVL1:         d.level = 4'd1;
            CODE_LVL2:         d.level = 4'd2;
            CODE_LVL3:         d.level = 4'd3;
            CODE_LVL4:         d.level = 4'd4;
            CODE_LVL5:         d.level = 4'd5;
            CODE_LVL6:         d.level = 4'd6;
            CODE_LVL7:         d.level = 4'd7;
            CODE_LVL8:         d.level = 4'd8;
            CODE_SENSOR_FAULT: d.valid = 1'b0;
            default:           d.valid = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] lvl);
        logic [6:0] s;
        case (lvl)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cistern_level_monitor_if.sv
// Level-code input and panel/pump output bundle of the cistern level monitor.
// The master side is the encoder/panel environment, the slave side the monitor.
interface cistern_level_monitor_if;
    logic [3:0] level_code;
    logic       fault_clr;
    logic [3:0] level;
    logic       level_valid;
    logic [6:0] seg;
    logic       pump_on;
    logic       overflow;
    logic       fault;

    modport master (
        output level_code, fault_clr,
        input  level, level_valid, seg, pump_on, overflow, fault
    );

    modport slave (
        input  level_code, fault_clr,
        output level, level_valid, seg, pump_on, overflow, fault
    );
endinterface

// File: rtl/cistern_code_debounce.sv
// Debounces the raw 4-bit level code. A code must be seen on
// STABLE_CYCLES consecutive samples before it is loaded into acc_code;
// accept pulses on every cycle acc_code is (re)loaded.
module cistern_code_debounce #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] level_code,
    output logic [3:0] acc_code,
    output logic       accept
);

    localparam int                CNT_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       code_q;
    logic [CNT_W-1:0] stab_cnt;
    logic             same;

    assign same   = (level_code == code_q);
    assign accept = same && (stab_cnt == CNT_MAX);

    // Sample the code, count consecutive matches and load the accepted code
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= 4'd0;
            stab_cnt <= '0;
            acc_code <= 4'd0;
        end else begin
            code_q <= level_code;
            if (!same) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
            if (accept) begin
                acc_code <= code_q;
            end
        end
    end

endmodule

// File: rtl/cistern_level_monitor.sv
// Cistern level monitor: debounces the float-switch level code, decodes it
// to 0..8, drives a 7-segment digit, a hysteretic fill-pump FSM and the
// overflow/fault flags. Optional macro DRY_RUN_TIMEOUT_EN adds a pump
// run-time limit (MAX_RUN_CYCLES without a level rise forces FAULT).
module cistern_level_monitor
    import cistern_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int LOW_THR        = 2,
    parameter int HIGH_THR       = 7,
    parameter int MAX_RUN_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    cistern_level_monitor_if.slave  bus
);

    if (STABLE_CYCLES < 2 || LOW_THR < 0 || LOW_THR >= HIGH_THR ||
        HIGH_THR > 8 || MAX_RUN_CYCLES < 2) begin : g_param_check
        $error("cistern_level_monitor: illegal parameter combination");
    end

    localparam logic [3:0] LOW_LVL  = 4'(LOW_THR);
    localparam logic [3:0] HIGH_LVL = 4'(HIGH_THR);

    logic [3:0] acc_code;
    logic       accept;
    logic       have_code;
    decode_t    dec;
    state_t     state;
    state_t     next_state;
    logic       run_timeout;

    logic [3:0] level_r;
    logic       level_valid_r;
    logic [6:0] seg_r;
    logic       pump_r;
    logic       overflow_r;
    logic       fault_r;

    cistern_code_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .level_code (bus.level_code),
        .acc_code   (acc_code),
        .accept     (accept)
    );

`ifdef DRY_RUN_TIMEOUT_EN
    localparam int               RUN_W   = $clog2(MAX_RUN_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_RUN_CYCLES - 1);

    logic [RUN_W-1:0] run_cnt;

    assign run_timeout = (state == ST_FILLING) && (run_cnt >= RUN_LIM);

    // Count pumping time; held at zero outside FILLING so entry starts fresh
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (state != ST_FILLING) begin
            run_cnt <= '0;
        end else if (dec.valid && (dec.level > level_r)) begin
            run_cnt <= '0;
        end else if (!run_timeout) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end
`else
    assign run_timeout = 1'b0;
`endif

    // Decode the accepted code and pick the next pump state
    always_comb begin
        dec        = decode_code(acc_code);
        next_state = state;
        if (!have_code) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!dec.valid) begin
                        next_state = ST_FAULT;
                    end else if (dec.level <= LOW_LVL) begin
                        next_state = ST_FILLING;
                    end
                end
                ST_FILLING: begin
                    if (!dec.valid) begin
                        next_state = ST_FAULT;
                    end else if (dec.level >= HIGH_LVL) begin
                        next_state = ST_IDLE;
                    end else if (run_timeout) begin
                        next_state = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_clr && dec.valid) begin
                        next_state = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Pump FSM with registered panel outputs; level/overflow hold during FAULT
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            have_code     <= 1'b0;
            level_r       <= 4'd0;
            level_valid_r <= 1'b0;
            seg_r         <= SEG_BLANK;
            pump_r        <= 1'b0;
            overflow_r    <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            have_code <= have_code | accept;
            state     <= next_state;
            pump_r    <= (next_state == ST_FILLING);
            fault_r   <= (next_state == ST_FAULT);
            if (have_code) begin
                if (next_state == ST_FAULT) begin
                    level_valid_r <= 1'b0;
                    seg_r         <= SEG_E;
                end else begin
                    level_valid_r <= 1'b1;
                    level_r       <= dec.level;
                    overflow_r    <= (dec.level == LEVEL_MAX);
                    seg_r         <= seg_of(dec.level);
                end
            end
        end
    end

    assign bus.level       = level_r;
    assign bus.level_valid = level_valid_r;
    assign bus.seg         = seg_r;
    assign bus.pump_on     = pump_r;
    assign bus.overflow    = overflow_r;
    assign bus.fault       = fault_r;

endmodule
